// File: rtl/scan_pkg.sv
// Shared constants and FSM state type for the lane scanner and its lane search.
package scan_pkg;

   localparam int unsigned LANES       = 8;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned DIV_DEFAULT = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/lane_search.sv
// Combinational search for the next set mask bit strictly above cur, wrapping 7->0.
// With cur = LANES-1 the result is the lowest set bit of the mask.
module lane_search
   import scan_pkg::*;
(
   input  logic [LANES-1:0] mask,
   input  logic [IDX_W-1:0] cur,
   output logic [IDX_W-1:0] nxt,
   output logic             wrapped,
   output logic             any
);

   logic [IDX_W-1:0] lane;

   always_comb begin
      nxt  = '0;
      lane = '0;
      // Walk offsets from farthest to nearest so the nearest set lane is the last write.
      // Offset LANES truncates to cur itself, which covers the single-lane re-select.
      for (int unsigned i = LANES; i >= 1; i--) begin
         lane = IDX_W'(cur + IDX_W'(i));
         if (mask[lane]) begin
            nxt = lane;
         end
      end
      any     = |mask;
      wrapped = any && (nxt <= cur);
   end

endmodule

// File: rtl/scan_index_seq.sv
// Round-robin lane index sequencer: holds each unmasked lane for DIV cycles and
// emits registered idx/idx_valid plus per-step (tick) and per-frame pulses.
module scan_index_seq
   import scan_pkg::*;
#(
   parameter int unsigned DIV = DIV_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [7:0]       mask,
   output logic [2:0]       idx,
   output logic             idx_valid,
   output logic             tick,
   output logic             frame_done
);

   localparam int unsigned      CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             tick_q, tick_d;
   logic             frame_q, frame_d;

   logic [IDX_W-1:0] adv_nxt;
   logic             adv_wrapped;
   logic             adv_any;
   logic [IDX_W-1:0] entry_nxt;
   logic             entry_any;
   logic             entry_wrapped_unused;

   lane_search u_adv_search (
      .mask    (mask),
      .cur     (idx_q),
      .nxt     (adv_nxt),
      .wrapped (adv_wrapped),
      .any     (adv_any)
   );

   lane_search u_entry_search (
      .mask    (mask),
      .cur     (IDX_W'(LANES - 1)),
      .nxt     (entry_nxt),
      .wrapped (entry_wrapped_unused),
      .any     (entry_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (en && entry_any) state_d = SCAN;
         SCAN: if (!en || !adv_any) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      tick_d  = 1'b0;
      frame_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en && entry_any) begin
               idx_d   = entry_nxt;
               valid_d = 1'b1;
            end else begin
               idx_d   = '0;
               valid_d = 1'b0;
            end
         end
         SCAN: begin
            // Exit wins over an advance landing on the same edge.
            if (!en || !adv_any) begin
               cnt_d   = '0;
               idx_d   = '0;
               valid_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               idx_d   = adv_nxt;
               tick_d  = 1'b1;
               frame_d = adv_wrapped;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         tick_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         tick_q  <= tick_d;
         frame_q <= frame_d;
      end
   end

   assign idx        = idx_q;
   assign idx_valid  = valid_q;
   assign tick       = tick_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_scan_index_seq.sv
// Bench for scan_index_seq: four instances (DIV = 1..4) share stimulus and are
// compared every cycle against a per-instance lane/dwell model.
module tb_scan_index_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] mask;

   logic [2:0] o_idx   [4];
   logic       o_val   [4];
   logic       o_tick  [4];
   logic       o_frame [4];

   int tests = 0;
   int fails = 0;

   int unsigned divs [4] = '{1, 2, 3, 4};
   bit          m_act   [4];
   int unsigned m_idx   [4];
   int unsigned m_left  [4];
   int unsigned m_tick  [4];
   int unsigned m_frame [4];

   always #5 clk = ~clk;

   scan_index_seq #(.DIV(1)) u_div1 (.clk(clk), .rst(rst), .en(en), .mask(mask),
      .idx(o_idx[0]), .idx_valid(o_val[0]), .tick(o_tick[0]), .frame_done(o_frame[0]));
   scan_index_seq #(.DIV(2)) u_div2 (.clk(clk), .rst(rst), .en(en), .mask(mask),
      .idx(o_idx[1]), .idx_valid(o_val[1]), .tick(o_tick[1]), .frame_done(o_frame[1]));
   scan_index_seq #(.DIV(3)) u_div3 (.clk(clk), .rst(rst), .en(en), .mask(mask),
      .idx(o_idx[2]), .idx_valid(o_val[2]), .tick(o_tick[2]), .frame_done(o_frame[2]));
   scan_index_seq #(.DIV(4)) u_div4 (.clk(clk), .rst(rst), .en(en), .mask(mask),
      .idx(o_idx[3]), .idx_valid(o_val[3]), .tick(o_tick[3]), .frame_done(o_frame[3]));

   function automatic int unsigned lowest_lane(input logic [7:0] m);
      for (int unsigned i = 0; i < 8; i++) begin
         if (m[i]) return i;
      end
      return 0;
   endfunction

   function automatic int unsigned lane_after(input logic [7:0] m, input int unsigned cur);
      for (int unsigned s = 1; s <= 8; s++) begin
         if (m[(cur + s) % 8]) return (cur + s) % 8;
      end
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_act[k] = 1'b0; m_idx[k] = 0; m_left[k] = 0; m_tick[k] = 0; m_frame[k] = 0;
      end
   endtask

   // One clock edge of the scanner as described in prose: dwell counted down.
   task automatic model_step(input int k);
      int unsigned nl;
      m_tick[k]  = 0;
      m_frame[k] = 0;
      if (!m_act[k]) begin
         if (en && mask != 8'h00) begin
            m_act[k]  = 1'b1;
            m_idx[k]  = lowest_lane(mask);
            m_left[k] = divs[k];
         end else begin
            m_idx[k] = 0;
         end
      end else if (!en || mask == 8'h00) begin
         m_act[k] = 1'b0; m_idx[k] = 0; m_left[k] = 0;
      end else if (m_left[k] == 1) begin
         nl         = lane_after(mask, m_idx[k]);
         m_frame[k] = (nl <= m_idx[k]) ? 1 : 0;
         m_tick[k]  = 1;
         m_idx[k]   = nl;
         m_left[k]  = divs[k];
      end else begin
         m_left[k] = m_left[k] - 1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      tests++;
      fails++;
      $error("FAIL %s observed=timeout expected=condition reached", tag);
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s.div%0d.idx", tag, divs[k]),   8'(o_idx[k]),   8'(m_idx[k]));
         check($sformatf("%s.div%0d.valid", tag, divs[k]), 8'(o_val[k]),   8'(m_act[k]));
         check($sformatf("%s.div%0d.tick", tag, divs[k]),  8'(o_tick[k]),  8'(m_tick[k]));
         check($sformatf("%s.div%0d.frame", tag, divs[k]), 8'(o_frame[k]), 8'(m_frame[k]));
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      for (int k = 0; k < 4; k++) model_step(k);
      #1;
      check_all(tag);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   initial begin
      int guard;
      rst  = 1'b1;
      en   = 1'b0;
      mask = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;
      run("idle", 2);

      // Asynchronous reset in the middle of a DIV=4 dwell on lane 5.
      en   = 1'b1;
      mask = 8'hFF;
      guard = 0;
      while (!(m_act[3] && m_idx[3] == 5) && guard < 100) begin
         cycle("scan_ff");
         guard++;
      end
      if (guard >= 100) timeout_fail("wait_idx5");
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("async_rst.div%0d.idx", divs[k]),   8'(o_idx[k]),  8'h00);
         check($sformatf("async_rst.div%0d.valid", divs[k]), 8'(o_val[k]),  8'h00);
         check($sformatf("async_rst.div%0d.tick", divs[k]),  8'(o_tick[k]), 8'h00);
      end
      model_reset();
      rst = 1'b0;
      run("post_rst", 3);

      en = 1'b0;
      cycle("exit");
      mask = 8'b1010_0101;
      en   = 1'b1;
      run("full_frame", 20);

      en = 1'b0;
      cycle("exit");
      mask = 8'b0001_0000;
      en   = 1'b1;
      run("single_lane", 15);

      en = 1'b0;
      cycle("exit");
      mask = 8'b0000_0011;
      en   = 1'b1;
      run("two_lane", 10);

      // Clear the current lane's bit part-way through a DIV=4 dwell on lane 1.
      en = 1'b0;
      cycle("exit");
      mask = 8'h0F;
      en   = 1'b1;
      guard = 0;
      while (!(m_act[3] && m_idx[3] == 1 && m_left[3] == 3) && guard < 100) begin
         cycle("mask_edit_pre");
         guard++;
      end
      if (guard >= 100) timeout_fail("wait_idx1");
      mask = 8'h0D;
      run("mask_edit", 6);
      mask = 8'h00;
      cycle("mask_zero");
      run("mask_zero_idle", 2);

      // Drop en on the very edge a DIV=4 advance is due.
      mask = 8'h0F;
      en   = 1'b1;
      guard = 0;
      while (!(m_act[3] && m_left[3] == 1) && guard < 100) begin
         cycle("collide_pre");
         guard++;
      end
      if (guard >= 100) timeout_fail("wait_dwell_end");
      en = 1'b0;
      cycle("collide");
      en = 1'b1;
      run("reenter", 6);

      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0:       mask = 8'h00;
               1:       mask = 8'h01 << $urandom_range(0, 7);
               default: mask = 8'($urandom);
            endcase
         end
         cycle("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
